mult_seq: RTL

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_add_step.sv | 14 +
 rtl/mult_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared constants and types for the sequential multiplier.
// Build option: MULT_SEQ_SIGNED_EN enables the signed MULT op.
package mult_pkg;

    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] MULT  = 6'd24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // An op code is accepted only if this build implements it.
    function automatic logic op_is_legal(input logic [5:0] sig);
`ifdef MULT_SEQ_SIGNED_EN
        return (sig == MULTU) || (sig == MULT);
`else
        return (sig == MULTU);
`endif
    endfunction

endpackage

// File: rtl/mult_add_step.sv
// Combinational WIDTH-bit adder with carry-out used by each shift-add step.
module mult_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Widen by one bit so the carry-out is kept.
    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, one multiplier bit per clock, LSB first.
// Build option: MULT_SEQ_SIGNED_EN adds the signed MULT op (magnitude
// conversion at start, conditional negation at finish).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start with a legal op; operands latched on accept
//   ST_RUN  | one add/shift step per cycle, WIDTH cycles, down-counter
//   ST_FIN  | load dataOut with the product, pulse done, back to idle
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           Signal,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     step_sum;
    logic                 step_cout;
    logic [2*WIDTH-1:0]   product;
    logic                 accept;

`ifdef MULT_SEQ_SIGNED_EN
    logic                 neg;
    logic                 sign_diff;
`endif

    assign accept = start && op_is_legal(Signal);
    assign busy   = (state != ST_IDLE);

    // Operand preparation at the start sample; signed ops use magnitudes.
    always_comb begin
        mag_a = dataA;
        mag_b = dataB;
`ifdef MULT_SEQ_SIGNED_EN
        sign_diff = 1'b0;
        if (Signal == MULT) begin
            if (dataA[WIDTH-1]) mag_a = -dataA;
            if (dataB[WIDTH-1]) mag_b = -dataB;
            sign_diff = dataA[WIDTH-1] ^ dataB[WIDTH-1];
        end
`endif
    end

    // Add the multiplicand to the upper half only when the current LSB is set.
    assign add_b = acc[0] ? mcand : '0;

    mult_add_step #(.WIDTH(WIDTH)) u_add_step (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (add_b),
        .sum  (step_sum),
        .cout (step_cout)
    );

    // Final product, negated when the original operand signs differed.
`ifdef MULT_SEQ_SIGNED_EN
    assign product = neg ? -acc : acc;
`else
    assign product = acc;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == '0) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // All registered state: FSM, counter, accumulator, operands and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            dataOut <= '0;
            done    <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mcand <= mag_a;
                        acc   <= {{WIDTH{1'b0}}, mag_b};
                        cnt   <= CNT_W'(WIDTH - 1);
`ifdef MULT_SEQ_SIGNED_EN
                        neg   <= sign_diff;
`endif
                    end
                end
                ST_RUN: begin
                    acc <= {step_cout, step_sum, acc[WIDTH-1:1]};
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                ST_FIN: begin
                    dataOut <= product;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
